// File: rtl/la_vpol_pkg.sv
// la_vpol_pkg: shared lane-FSM state encoding for the polarity receiver
package la_vpol_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/la_polrx_lane.sv
// la_polrx_lane: one lane of the polarity receiver (training-word search, confirm, lock)
module la_polrx_lane
    import la_vpol_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   PATTERN = 8'hB4,
    parameter int             MATCHES = 4,
    parameter                 PROP    = "DEFAULT"
) (
    input  logic clk,
    input  logic nreset,
    input  logic train_i,
    input  logic retrain_i,
    input  logic a_i,
    output logic z_o,
    output logic inv_o,
    output logic locked_o
);

    localparam int CW = $clog2(MATCHES + 1);
    localparam int PW = $clog2(W);

    logic [W-1:0]  sr_q;
    logic          z_q;
    state_e        state_q, state_d;
    logic          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          inv_q, inv_d;
    logic          locked_q, locked_d;

    logic          hit_p, hit_n, hit_cand;
    logic [CW-1:0] cnt_inc;

    // Hits are judged on the registered shift register, one cycle behind the pin.
    assign hit_p    = (sr_q == PATTERN);
    assign hit_n    = (sr_q == ~PATTERN);
    assign hit_cand = cand_q ? hit_n : hit_p;
    assign cnt_inc  = cnt_q + CW'(1);

    // Datapath: the shift register and corrected output run regardless of train.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sr_q <= '0;
            z_q  <= 1'b0;
        end else begin
            sr_q <= {sr_q[W-2:0], a_i};
            z_q  <= a_i ^ inv_q;
        end
    end

    // Next-state: retrain wins over everything, otherwise the FSM only moves while training.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        inv_d    = inv_q;
        locked_d = locked_q;
        if (retrain_i) begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
            cnt_d    = '0;
            phase_d  = '0;
        end else if (train_i) begin
            case (state_q)
                ST_SEARCH: begin
                    if (hit_p || hit_n) begin
                        if (MATCHES == 1) begin
                            state_d  = ST_LOCKED;
                            inv_d    = hit_n;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM;
                            cand_d  = hit_n;
                            cnt_d   = CW'(1);
                            phase_d = '0;
                        end
                    end
                end
                ST_CONFIRM: begin
                    phase_d = phase_q + PW'(1);
                    if (phase_q == PW'(W - 1)) begin
                        if (hit_cand) begin
                            cnt_d   = cnt_inc;
                            phase_d = '0;
                            if (cnt_inc == CW'(MATCHES)) begin
                                state_d  = ST_LOCKED;
                                inv_d    = cand_q;
                                locked_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            cnt_d   = '0;
                            phase_d = '0;
                        end
                    end
                end
                ST_LOCKED: ;
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // FSM and status registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_SEARCH;
            cand_q   <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= '0;
            inv_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            inv_q    <= inv_d;
            locked_q <= locked_d;
        end
    end

    assign z_o      = z_q;
    assign inv_o    = inv_q;
    assign locked_o = locked_q;

endmodule

// File: rtl/la_vpolrx.sv
// la_vpolrx: N independent lane-polarity receivers
module la_vpolrx
    import la_vpol_pkg::*;
#(
    parameter int           N       = 1,
    parameter int           W       = 8,
    parameter logic [W-1:0] PATTERN = 8'hB4,
    parameter int           MATCHES = 4,
    parameter               PROP    = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         train,
    input  logic         retrain,
    input  logic [N-1:0] a,
    output logic [N-1:0] z,
    output logic [N-1:0] inv,
    output logic [N-1:0] locked
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        la_polrx_lane #(
            .W       (W),
            .PATTERN (PATTERN),
            .MATCHES (MATCHES),
            .PROP    (PROP)
        ) u_lane (
            .clk       (clk),
            .nreset    (nreset),
            .train_i   (train),
            .retrain_i (retrain),
            .a_i       (a[i]),
            .z_o       (z[i]),
            .inv_o     (inv[i]),
            .locked_o  (locked[i])
        );
    end

endmodule

// File: tb/tb_la_vpolrx.sv
// tb_la_vpolrx: directed vectors for the lane-polarity receiver (1-lane and 4-lane instances)
module tb_la_vpolrx;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       train = 1'b0;
    logic       retrain = 1'b0;
    logic       a1 = 1'b0;
    logic [3:0] a4 = '0;
    logic       z1, inv1, lk1;
    logic [3:0] z4, inv4, lk4;

    int n_cmp = 0;
    int n_bad = 0;

    la_vpolrx #(.N(1)) u1 (
        .clk(clk), .nreset(nreset), .train(train), .retrain(retrain),
        .a(a1), .z(z1), .inv(inv1), .locked(lk1)
    );

    la_vpolrx #(.N(4)) u4 (
        .clk(clk), .nreset(nreset), .train(train), .retrain(retrain),
        .a(a4), .z(z4), .inv(inv4), .locked(lk4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] words;
        int          nw;
        int          lock_at;
        logic        exp_inv;
    } vec_t;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic b);
        a1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic rstep(input logic b);
        retrain = 1'b1;
        step(b);
        retrain = 1'b0;
    endtask

    task automatic feed_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) step(w[i]);
    endtask

    task automatic do_reset;
        nreset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a1 = 1'($urandom);
            a4 = 4'($urandom);
            @(posedge clk);
            #1;
            chk("rst_z1", {3'b0, z1}, 4'd0);
            chk("rst_inv1", {3'b0, inv1}, 4'd0);
            chk("rst_lk1", {3'b0, lk1}, 4'd0);
            chk("rst_z4", z4, 4'd0);
            chk("rst_inv4", inv4, 4'd0);
            chk("rst_lk4", lk4, 4'd0);
        end
        a4 = '0;
        nreset = 1'b1;
    endtask

    initial begin
        vec_t       tv[6];
        logic [7:0] b4 = 8'hB4;
        logic [7:0] pw[4];
        int         off[4];
        logic [3:0] exp4;
        logic       b;

        tv[0] = '{64'hB4B4B4B4_00000000, 4, 33, 1'b0};
        tv[1] = '{64'h4B4B4B4B_00000000, 4, 33, 1'b1};
        tv[2] = '{64'hB4B4B4FF_B4B4B4B4, 8, 65, 1'b0};
        tv[3] = '{64'hB4B4B44B_00000000, 4, 0,  1'b0};
        tv[4] = '{64'hB4B4B400_00000000, 3, 0,  1'b0};
        tv[5] = '{64'h4B4B4B4B_4B000000, 5, 33, 1'b1};

        // reset, then a full training stream with train held low must not lock
        do_reset;
        train = 1'b0;
        for (int s = 0; s < 24; s++) begin
            step(b4[7 - (s % 8)]);
            chk("notrain_lk1", {3'b0, lk1}, 4'd0);
        end

        // word-sequence vectors on the single-lane instance
        for (int v = 0; v < 6; v++) begin
            do_reset;
            train = 1'b1;
            for (int s = 1; s <= tv[v].nw * 8 + 1; s++) begin
                step(s <= tv[v].nw * 8 ? tv[v].words[64 - s] : 1'b0);
                chk($sformatf("v%0d_lock_s%0d", v, s), {3'b0, lk1},
                    {3'b0, (tv[v].lock_at != 0 && s >= tv[v].lock_at)});
            end
            chk($sformatf("v%0d_inv", v), {3'b0, inv1}, {3'b0, tv[v].exp_inv});
            if (tv[v].lock_at != 0) begin
                for (int k = 0; k < 8; k++) begin
                    b = 1'($urandom);
                    step(b);
                    chk($sformatf("v%0d_z%0d", v, k), {3'b0, z1}, {3'b0, b ^ tv[v].exp_inv});
                end
            end
            #2 nreset = 1'b0;
            #1;
            chk($sformatf("v%0d_async_lk", v), {3'b0, lk1}, 4'd0);
            chk($sformatf("v%0d_async_inv", v), {3'b0, inv1}, 4'd0);
        end

        // train dropped for one word mid-CONFIRM: phase/cnt freeze, lock slips by 8 cycles
        do_reset;
        for (int s = 1; s <= 41; s++) begin
            train = !(s >= 12 && s <= 19);
            step(b4[7 - ((s - 1) % 8)]);
            chk($sformatf("frz_lock_s%0d", s), {3'b0, lk1}, {3'b0, s >= 41});
        end
        train = 1'b1;

        // retrain: after a lock, at cnt==2, and on the exact lock cycle
        do_reset;
        train = 1'b1;
        for (int i = 0; i < 4; i++) feed_word(8'h4B);
        chk("rt_pre_lk", {3'b0, lk1}, 4'd0);
        step(1'b0);
        chk("rt_lock1_lk", {3'b0, lk1}, 4'd1);
        chk("rt_lock1_inv", {3'b0, inv1}, 4'd1);
        rstep(1'b0);
        chk("rt_clr_lk", {3'b0, lk1}, 4'd0);
        chk("rt_clr_inv", {3'b0, inv1}, 4'd1);
        for (int i = 0; i < 8; i++) step(1'b0);
        feed_word(8'hB4);
        feed_word(8'hB4);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        rstep(1'b0);
        chk("rt_cnt2_lk", {3'b0, lk1}, 4'd0);
        chk("rt_cnt2_inv", {3'b0, inv1}, 4'd1);
        for (int i = 0; i < 8; i++) step(1'b0);
        for (int i = 0; i < 4; i++) feed_word(8'hB4);
        rstep(1'b0);
        chk("rt_lockcyc_lk", {3'b0, lk1}, 4'd0);
        chk("rt_lockcyc_inv", {3'b0, inv1}, 4'd1);
        for (int i = 0; i < 8; i++) step(1'b0);
        for (int i = 0; i < 4; i++) feed_word(8'hB4);
        chk("rt_fresh_pre_lk", {3'b0, lk1}, 4'd0);
        step(1'b0);
        chk("rt_fresh_lk", {3'b0, lk1}, 4'd1);
        chk("rt_fresh_inv", {3'b0, inv1}, 4'd0);

        // four lanes, mixed polarity, staggered starts
        do_reset;
        train = 1'b1;
        pw  = '{8'hB4, 8'h4B, 8'hB4, 8'h4B};
        off = '{0, 3, 6, 9};
        for (int s = 1; s <= 45; s++) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = s - 1 - off[k];
                a4[k] = (idx >= 0 && idx < 32) ? pw[k][7 - (idx % 8)] : 1'b0;
                exp4[k] = (s >= off[k] + 33);
            end
            step(1'b0);
            chk($sformatf("n4_lock_s%0d", s), lk4, exp4);
        end
        chk("n4_inv", inv4, 4'b1010);
        chk("n4_lk", lk4, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
